// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and helpers for the MEM-stage data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        n = 3'd4;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-lane storage with a 4-byte big-endian window at i_addr.
// Lane 3 (bits 31:24) is the byte at i_addr; higher addresses wrap.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 16384,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    output logic [31:0]   o_rdata
);

    logic [7:0]    r_mem [DEPTH_BYTES];
    logic [31:0]   r_rdata;
    logic [AW-1:0] w_a1;
    logic [AW-1:0] w_a2;
    logic [AW-1:0] w_a3;

    assign w_a1 = i_addr + AW'(1);
    assign w_a2 = i_addr + AW'(2);
    assign w_a3 = i_addr + AW'(3);

    always_ff @(posedge clk) begin
        if (i_we[3]) r_mem[i_addr] <= i_wdata[31:24];
        if (i_we[2]) r_mem[w_a1]   <= i_wdata[23:16];
        if (i_we[1]) r_mem[w_a2]   <= i_wdata[15:8];
        if (i_we[0]) r_mem[w_a3]   <= i_wdata[7:0];
        if (i_re) begin
            r_rdata <= {r_mem[i_addr], r_mem[w_a1],
                        r_mem[w_a2], r_mem[w_a3]};
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// Big-endian data memory controller with valid/ready request/response.
// DMEM_ALIGN_CHECK_EN: misaligned half/word accesses fault instead of masking.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 16384,
    parameter int ADDR_W      = 32,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_cnt;
    logic [1:0]    w_cnt_nxt;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic          r_err;
    logic [AW-1:0] r_addr;

    logic          w_accept;
    logic          w_err;
    logic          w_range_err;
    logic          w_align_err;
    logic [ADDR_W:0] w_end;
    logic [AW-1:0] w_req_addr;
    logic [AW-1:0] w_mem_addr;
    logic [3:0]    w_mem_we;
    logic [31:0]   w_mem_wdata;
    logic          w_mem_re;
    logic [31:0]   w_mem_rdata;
    logic [31:0]   w_ext;

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid & req_ready;

    // Range is judged on the raw address, before any low-bit masking.
    assign w_end = {1'b0, req_addr}
                 + (ADDR_W+1)'(size_bytes(req_size));
    assign w_range_err = (w_end > (ADDR_W+1)'(DEPTH_BYTES))
                       | (req_size == SZ_RSVD);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_align_err = ((req_size == SZ_HALF) & req_addr[0])
                       | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
    assign w_req_addr  = req_addr[AW-1:0];
`else
    assign w_align_err = 1'b0;
    always_comb begin
        w_req_addr = req_addr[AW-1:0];
        if (req_size == SZ_HALF) w_req_addr[0]   = 1'b0;
        if (req_size == SZ_WORD) w_req_addr[1:0] = 2'b00;
    end
`endif

    assign w_err = w_range_err | w_align_err;

    assign w_mem_addr = (r_state == IDLE) ? w_req_addr : r_addr;

    always_comb begin
        w_mem_we    = 4'b0000;
        w_mem_wdata = 32'd0;
        if (w_accept & req_we & ~w_err & rst_n) begin
            case (req_size)
                SZ_BYTE: begin
                    w_mem_we    = 4'b1000;
                    w_mem_wdata = {req_wdata[7:0], 24'd0};
                end
                SZ_HALF: begin
                    w_mem_we    = 4'b1100;
                    w_mem_wdata = {req_wdata[15:0], 16'd0};
                end
                default: begin
                    w_mem_we    = 4'b1111;
                    w_mem_wdata = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_re    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (req_we || READ_LAT == 1) begin
                        w_state_nxt = RESP;
                        w_mem_re    = ~req_we & ~w_err;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 2'(READ_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt <= 2'd1) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 2'd0;
                    w_mem_re    = ~r_we & ~r_err;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_err      <= w_err;
                r_addr     <= w_req_addr;
            end
        end
    end

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_mem_addr),
        .i_we    (w_mem_we),
        .i_wdata (w_mem_wdata),
        .i_re    (w_mem_re),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_ext = w_mem_rdata;
        case (r_size)
            SZ_BYTE: w_ext = {{24{~r_unsigned & w_mem_rdata[31]}},
                              w_mem_rdata[31:24]};
            SZ_HALF: w_ext = {{16{~r_unsigned & w_mem_rdata[31]}},
                              w_mem_rdata[31:16]};
            default: w_ext = w_mem_rdata;
        endcase
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = (rsp_valid & ~r_we & ~r_err) ? w_ext : 32'd0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (READ_LAT=3, 1 KiB).
module tb_data_memory_ctrl;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk = 0;
    int n_err = 0;

    data_memory_ctrl #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (32),
        .READ_LAT    (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction; returns data, error and cycles to rsp_valid.
    task automatic xfer(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int lat);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        rd  = 32'hxxxxxxxx;
        err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat != 99) begin
            rd  = rsp_rdata;
            err = rsp_err;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;
    logic [31:0] d0;
    int          bad;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err",   {31'd0, rsp_err},   32'd0);

        xfer(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er, lt);
        chk("st_w_lat", lt, 1);
        chk("st_w_err", {31'd0, er}, 32'd0);
        chk("st_w_rd",  rd, 32'd0);

        xfer(0, 2'b00, 1, 32'h10, 0, rd, er, lt);
        chk("ld_b10_lat", lt, LAT);
        chk("ld_b10", rd, 32'h000000DE);
        xfer(0, 2'b00, 1, 32'h11, 0, rd, er, lt);
        chk("ld_b11", rd, 32'h000000AD);
        xfer(0, 2'b00, 1, 32'h12, 0, rd, er, lt);
        chk("ld_b12", rd, 32'h000000BE);
        xfer(0, 2'b00, 1, 32'h13, 0, rd, er, lt);
        chk("ld_b13", rd, 32'h000000EF);
        xfer(0, 2'b01, 1, 32'h10, 0, rd, er, lt);
        chk("ld_hu10", rd, 32'h0000DEAD);
        xfer(0, 2'b01, 0, 32'h10, 0, rd, er, lt);
        chk("ld_hs10", rd, 32'hFFFFDEAD);

        xfer(1, 2'b00, 0, 32'h20, 32'h12345680, rd, er, lt);
        xfer(0, 2'b00, 0, 32'h20, 0, rd, er, lt);
        chk("ld_bs20", rd, 32'hFFFFFF80);
        xfer(0, 2'b00, 1, 32'h20, 0, rd, er, lt);
        chk("ld_bu20", rd, 32'h00000080);

        xfer(1, 2'b01, 0, 32'h30, 32'h0000A55A, rd, er, lt);
        xfer(0, 2'b10, 0, 32'h30, 0, rd, er, lt);
        chk("ld_w30_hi", rd[31:16], 32'h0000A55A);

        xfer(1, 2'b10, 0, DEPTH-4, 32'h11223344, rd, er, lt);
        chk("st_top_err", {31'd0, er}, 32'd0);
        xfer(0, 2'b10, 0, DEPTH-2, 0, rd, er, lt);
        chk("ld_oob_err", {31'd0, er}, 32'd1);
        chk("ld_oob_rd",  rd, 32'd0);
        chk("ld_oob_lat", lt, LAT);
        xfer(1, 2'b10, 0, DEPTH-2, 32'hCAFEF00D, rd, er, lt);
        chk("st_oob_err", {31'd0, er}, 32'd1);
        chk("st_oob_lat", lt, 1);
        xfer(0, 2'b10, 0, DEPTH-4, 0, rd, er, lt);
        chk("ld_top_w", rd, 32'h11223344);
        xfer(0, 2'b00, 1, DEPTH-1, 0, rd, er, lt);
        chk("ld_last_b", rd, 32'h00000044);
        chk("ld_last_err", {31'd0, er}, 32'd0);
        xfer(0, 2'b01, 1, DEPTH-2, 0, rd, er, lt);
        chk("ld_last_h", rd, 32'h00003344);
        xfer(0, 2'b11, 0, 32'h10, 0, rd, er, lt);
        chk("rsvd_err", {31'd0, er}, 32'd1);
        chk("rsvd_rd",  rd, 32'd0);

        // Stalled response: latency, stability and no request acceptance.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        bad = 0; lt = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (req_ready) bad++;
            if (rsp_valid) begin
                lt = k;
                break;
            end
        end
        chk("stall_lat", lt, LAT);
        d0 = rsp_rdata;
        chk("stall_data", d0, 32'hDEADBEEF);
        repeat (5) begin
            @(negedge clk);
            if (rsp_rdata !== d0 || !rsp_valid || req_ready) bad++;
        end
        chk("stall_stable", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_ready", {31'd0, req_ready}, 32'd1);

        // Reset one cycle after a load is accepted drops the response.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
        req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        bad = 0;
        repeat (6) begin
            if (rsp_valid) bad++;
            @(negedge clk);
        end
        chk("rst_mid_norsp", bad, 0);
        xfer(0, 2'b10, 0, 32'h10, 0, rd, er, lt);
        chk("rst_keep_mem", rd, 32'hDEADBEEF);

        xfer(0, 2'b01, 1, 32'h11, 0, rd, er, lt);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_h_err", {31'd0, er}, 32'd1);
        chk("mis_h_rd",  rd, 32'd0);
`else
        chk("mis_h_err", {31'd0, er}, 32'd0);
        chk("mis_h_rd",  rd, 32'h0000DEAD);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised byte-addressed, big-endian data memory with a valid/ready request/response interface for the datapath's MEM stage. Supports byte, half-word and word loads and stores, with signed or unsigned load extension and configurable read latency. Out-of-range accesses are flagged with an error response.

Parameters:
DEPTH_BYTES, 16384, memory size in bytes; must be a power of two and at least 4.
ADDR_W, 32, request address width.
READ_LAT, 1, cycles from request acceptance to load response; range 1 to 4.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  access size: 00 = byte, 01 = half-word, 10 = word, 11 = reserved (error).
req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-justified.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  32  load result; 0 for stores and errors.
rsp_err  out  1  access faulted.

Behaviour:
- Storage: array of 8-bit entries, DEPTH_BYTES deep. Contents are not cleared by reset.
- Byte order is big-endian. The byte at address A occupies bits [31:24] of a word access at A.
- FSM has three states: IDLE, WAIT, RESP.
  - req_ready = 1 only in IDLE.
  - A request is accepted when req_valid & req_ready. On acceptance, all request fields are latched.
- Stores:
  - The write commits on the acceptance edge.
  - Store sizes: byte writes req_wdata[7:0] at A; half-word writes [15:8] at A and [7:0] at A+1; word writes four bytes, MSB first.
  - Next state is RESP, so a store response appears 1 cycle after acceptance.
- Loads:
  - Next state is WAIT, with a counter loaded to READ_LAT-1. When READ_LAT = 1, WAIT is skipped and the FSM goes straight to RESP.
  - Read data is sampled when entering RESP. rsp_valid rises exactly READ_LAT cycles after acceptance.
  - Extension: a byte load takes bit 7 as the sign bit; a half-word load takes bit 15.
- RESP state:
  - rsp_valid = 1, and outputs stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, the FSM returns to IDLE. A new request is accepted no earlier than the following cycle, so there is no same-cycle handoff.
- Errors:
  - Error conditions: A + size_bytes > DEPTH_BYTES, or req_size = 11.
  - On error: the store is suppressed, rsp_err = 1, rsp_rdata = 0, and the response timing is unchanged.
- Reset:
  - rst_n = 0 at a clock edge forces IDLE, with req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and the counter at 0.
  - An in-flight load is dropped and produces no response. A store already committed stays committed.
- Store-then-load to the same address returns the new data, because the store commits before any later acceptance.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: a half-word access with A[0] != 0 or a word access with A[1:0] != 0 is an error. The write is suppressed and rsp_err = 1.
- Undefined: low address bits are masked (half-word: A & ~1; word: A & ~3) and the access proceeds without error.

Decomposition:
- Package dmem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the state enum IDLE/WAIT/RESP;
  - the function size_bytes(size).
- One sub-module, dmem_byte_array: a byte-lane storage array with four write enables, a 4-byte big-endian read port at base address A, and a registered read. The controller owns the FSM, extension, error logic and handshake.

Test Plan:
- Word store of 0xDEADBEEF at 0x10, then byte loads of 0x10 to 0x13 (unsigned) -> 0xDE, 0xAD, 0xBE, 0xEF.
- Byte store of 0x80 at 0x20, then a signed byte load -> 0xFFFFFF80; an unsigned byte load -> 0x00000080.
- Word load at DEPTH_BYTES-2 -> rsp_err = 1, rdata = 0. A store to the same address leaves memory unchanged, confirmed by a read-back.
- READ_LAT = 3, word load with rsp_ready held at 0 for 5 cycles -> rsp_valid rises 3 cycles after acceptance, data stays stable while stalled, and req_ready = 0 throughout.
- rst_n asserted 1 cycle after a load is accepted -> no response appears; req_ready = 1 on the cycle after reset releases.
- Half-word load at 0x11 -> error with DMEM_ALIGN_CHECK_EN defined. Without the macro, it returns the half-word at 0x10.
